// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - RV32 load/store unit doing read-modify-write sub-word stores on a mem_1r1w
// Define LSU_MISALIGN_CHK_EN to turn misaligned H/W accesses into error responses.
module lsu_rmw #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_dout,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_din,
  output logic              mem_we
);

`ifdef LSU_MISALIGN_CHK_EN
  localparam bit MISALIGN_CHK = 1'b1;
`else
  localparam bit MISALIGN_CHK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, MERGE, RESP} state_t;

  state_t              state;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;
  logic                req_bad;

  wire unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

  // Byte and unsigned loads never fault; BU/HU are load-only encodings.
  always_comb begin
    req_bad = 1'b0;
    case (req_funct3)
      3'b000:         req_bad = 1'b0;
      3'b001:         req_bad = MISALIGN_CHK & req_addr[0];
      3'b010:         req_bad = MISALIGN_CHK & (|req_addr[1:0]);
      3'b100, 3'b101: req_bad = req_we;
      default:        req_bad = 1'b1;
    endcase
  end

  always_comb begin
    rd_byte   = mem_rd_dout[{addr_q[1:0], 3'b000} +: 8];
    rd_half   = mem_rd_dout[{addr_q[1], 4'b0000} +: 16];
    load_data = mem_rd_dout;
    case (f3_q)
      3'b000:  load_data = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{(DATA_W-16){rd_half[15]}}, rd_half};
      3'b100:  load_data = {{(DATA_W-8){1'b0}}, rd_byte};
      3'b101:  load_data = {{(DATA_W-16){1'b0}}, rd_half};
      default: load_data = mem_rd_dout;
    endcase
  end

  // Only SB (funct3 000) and SH (001) reach MERGE.
  always_comb begin
    merged = mem_rd_dout;
    if (f3_q[0])
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    else
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  assign req_ready   = rst & (state == IDLE);
  assign mem_rd_addr = addr_q[ADDR_W+1:2];
  assign mem_wr_addr = addr_q[ADDR_W+1:2];
  assign mem_wr_din  = (state == MERGE) ? merged : wdata_q;
  assign mem_we      = rst & ((state == WR) | (state == MERGE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            addr_q     <= req_addr[ADDR_W+1:0];
            wdata_q    <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (req_bad) begin
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (req_we && req_funct3 == 3'b010) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD:    state <= we_q ? MERGE : DATA;
        DATA: begin
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        WR, MERGE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit that sits directly upstream of the core's mem_1r1w data memory and is its only driver.
- Accepts RV32 byte, halfword and word loads and stores over a valid/ready handshake.
- mem_1r1w has no byte enables, so SB/SH are done as read-modify-write.
- Sign/zero-extends load data and returns one response per accepted request.

Parameters:
- ADDR_W, 4, memory word-address width; must match mem_1r1w depth parameter (16 words).
- DATA_W, 32, data width; fixed at 32, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE with rst=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3; valid with resp_valid.
- mem_rd_addr  out  ADDR_W  to mem_1r1w rd_addr0.
- mem_rd_dout  in  32  from mem_1r1w rd_dout0; valid the cycle after the address is presented.
- mem_wr_addr  out  ADDR_W  to wr_addr0.
- mem_wr_din  out  32  to wr_din0.
- mem_we  out  1  to we0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset (rst=0 at edge): state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0. Latched address and data are cleared.
- Combinational gating: mem_we=0 and req_ready=0 whenever rst=0.
- Word index: req_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- States: IDLE, RD, DATA, WR, MERGE, RESP.
- Accept: req_valid & req_ready at an edge latches we, funct3, addr and wdata.
  - Error case → RESP.
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- RD: mem_rd_addr = latched word index. Next state is DATA for loads, MERGE for stores.
- DATA: extracts the lane from mem_rd_dout using addr[1:0] (B) or addr[1] (H).
  - Sign-extends for B/H, zero-extends for BU/HU.
  - Registers the result into resp_rdata, then → RESP.
- WR: mem_we=1, mem_wr_addr=index, mem_wr_din=req_wdata → RESP.
- MERGE: mem_we=1, mem_wr_din = mem_rd_dout with the target byte/half lane replaced by wdata[7:0] / wdata[15:0] → RESP.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
- Latency, counting the accept edge as cycle 0 and giving the resp_valid cycle:
  - Load: 3.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Back-to-back throughput: next accept is possible on the cycle after RESP.
- mem_we is 0 in every state except WR and MERGE.
- mem_rd_addr and mem_wr_addr hold the latched index in all non-IDLE states.
- Errors: H with addr[0]=1, W with addr[1:0]≠0, store with funct3 BU/HU, or any undefined funct3.
  - No memory access.
  - resp_err=1, resp_rdata=0.
- Reset mid-operation: the operation is aborted. If rst=0 during MERGE or WR, no write occurs (mem_we gated). No response is issued.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: misalignment produces an error response as above.
- Undefined:
  - Alignment bits are ignored: H uses addr[1] only, W ignores addr[1:0].
  - Only illegal funct3 raises resp_err.
  - Misaligned requests access memory normally.

Test Plan:
- Write then read word: SW addr 0x0 wdata 0x87654321 → mem_we pulse 1 cycle at index 0; resp_valid at cycle 2. LW addr 0x0 → resp_rdata=0x87654321 at cycle 3, resp_err=0.
- Sign/zero extend: with word0=0x87654321, LB addr 0x3 → 0xFFFFFF87; LBU addr 0x3 → 0x00000087; LH addr 0x2 → 0xFFFF8765; LHU addr 0x0 → 0x00004321.
- RMW: SB addr 0x1 wdata 0x123456AA → word0=0x8765AA21. SH addr 0x6 wdata 0xBEEF onto word1=0 → word1=0xBEEF0000. Confirm both by LW.
- Misaligned (LSU_MISALIGN_CHK_EN defined): LW addr 0x2 → resp_valid with resp_err=1, rdata=0 at cycle 1; mem_we never asserted. Rebuild undefined: same request returns word0.
- Reset mid-RMW: SB addr 0x0 wdata 0x55, drive rst=0 during the MERGE cycle → mem_we stays 0, word0 unchanged, no resp_valid; req_ready=1 the first cycle with rst=1.
- Wrap: SW addr 0x40 wdata 0xCAFEF00D (ADDR_W=4) → written to index 0; LW addr 0x0 returns 0xCAFEF00D.
